// File: rtl/gpio_trig_pkg.sv
// Shared types, default widths and the zero-means-one clamp used by the
// GPIO trigger sequencer.
package gpio_trig_pkg;

   localparam int DEF_CNTR_WIDTH  = 32;
   localparam int DEF_PULSE_WIDTH = 16;
   localparam int CLAMP_WIDTH     = 32;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DELAY,
      HIGH,
      LOW
   } state_t;

   // A programmed length or count of zero behaves as one.
   function automatic logic [CLAMP_WIDTH-1:0] clamp_min1(input logic [CLAMP_WIDTH-1:0] x);
      return (x == '0) ? CLAMP_WIDTH'(1) : x;
   endfunction

endpackage

// File: rtl/gpio_trigger_sequencer_sync.sv
// Two-flop synchronizer for the raw GPIO trigger pin followed by a
// rising-edge detector; ext_rise is high for exactly one cycle per edge.
module trig_sync_edge (
   input  logic aclk,
   input  logic aresetn,
   input  logic ext_trig,
   output logic ext_rise
);

   logic [1:0] sync_q;
   logic       edge_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so each stage takes the previous stage's old value.
         sync_q <= {sync_q[0], ext_trig};
         edge_q <= sync_q[1];
      end
   end

   assign ext_rise = sync_q[1] & ~edge_q;

endmodule

// File: rtl/gpio_trigger_sequencer.sv
// Armable trigger sequencer: waits for a soft or external trigger, delays,
// then emits a burst of pulses with programmable width, period and count.
module gpio_trigger_sequencer
   import gpio_trig_pkg::*;
#(
   parameter int CNTR_WIDTH  = DEF_CNTR_WIDTH,
   parameter int PULSE_WIDTH = DEF_PULSE_WIDTH
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   arm,
   input  logic                   disarm,
   input  logic                   soft_trig,
   input  logic                   ext_trig,
   input  logic [CNTR_WIDTH-1:0]  cfg_delay,
   input  logic [PULSE_WIDTH-1:0] cfg_width,
   input  logic [CNTR_WIDTH-1:0]  cfg_period,
   input  logic [PULSE_WIDTH-1:0] cfg_count,
   input  logic                   cfg_rearm,
   output logic                   trig_out,
   output logic                   armed,
   output logic                   busy,
   output logic                   done,
   output logic [PULSE_WIDTH-1:0] pulse_cnt
);

   state_t                 state;
   logic [CNTR_WIDTH-1:0]  cnt;
   logic                   ev_q;
   logic                   ext_rise;

   logic [CNTR_WIDTH-1:0]  sh_delay;
   logic [CNTR_WIDTH-1:0]  sh_low_m1;
   logic [PULSE_WIDTH-1:0] sh_width_m1;
   logic [PULSE_WIDTH-1:0] sh_count;
   logic                   sh_rearm;

   logic [PULSE_WIDTH-1:0] width_eff;
   logic [PULSE_WIDTH-1:0] count_eff;
   logic [CNTR_WIDTH-1:0]  width_ext;
   logic [CNTR_WIDTH-1:0]  low_m1_next;
   logic                   burst_end;
   logic                   latch_cfg;
   logic                   go_high;

   trig_sync_edge u_sync (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .ext_trig (ext_trig),
      .ext_rise (ext_rise)
   );

   assign width_eff = PULSE_WIDTH'(clamp_min1(CLAMP_WIDTH'(cfg_width)));
   assign count_eff = PULSE_WIDTH'(clamp_min1(CLAMP_WIDTH'(cfg_count)));
   assign width_ext = CNTR_WIDTH'(width_eff);

   // Low time is period minus high time, but never shorter than one cycle.
   assign low_m1_next = (cfg_period > width_ext) ? cfg_period - width_ext - CNTR_WIDTH'(1) : '0;

   assign burst_end = (state == HIGH) && (cnt == '0) && (pulse_cnt == sh_count);
   assign latch_cfg = !disarm && (((state == IDLE) && arm) || (burst_end && sh_rearm));
   assign go_high   = !disarm &&
                      (((state == ARMED) && ev_q && (sh_delay == '0)) ||
                       (((state == DELAY) || (state == LOW)) && (cnt == '0)));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sh_delay    <= '0;
         sh_low_m1   <= '0;
         sh_width_m1 <= '0;
         sh_count    <= '0;
         sh_rearm    <= 1'b0;
      end else if (latch_cfg) begin
         sh_delay    <= cfg_delay;
         sh_low_m1   <= low_m1_next;
         sh_width_m1 <= width_eff - PULSE_WIDTH'(1);
         sh_count    <= count_eff;
         sh_rearm    <= cfg_rearm;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         cnt       <= '0;
         ev_q      <= 1'b0;
         trig_out  <= 1'b0;
         armed     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pulse_cnt <= '0;
      end else begin
         // NOTE: assigned first on every edge so done can only ever be a one-cycle pulse.
         done <= 1'b0;
         // Trigger events are registered once and only while armed; nothing queues.
         ev_q <= !disarm && !ev_q && (state == ARMED) && (soft_trig || ext_rise);

         if (disarm) begin
            state    <= IDLE;
            trig_out <= 1'b0;
            armed    <= 1'b0;
            busy     <= 1'b0;
         end else if (go_high) begin
            state     <= HIGH;
            trig_out  <= 1'b1;
            armed     <= 1'b0;
            busy      <= 1'b1;
            cnt       <= CNTR_WIDTH'(sh_width_m1);
            pulse_cnt <= pulse_cnt + PULSE_WIDTH'(1);
         end else begin
            case (state)
               IDLE: begin
                  if (arm) begin
                     state     <= ARMED;
                     armed     <= 1'b1;
                     pulse_cnt <= '0;
                  end
               end
               ARMED: begin
                  if (ev_q) begin
                     state <= DELAY;
                     armed <= 1'b0;
                     busy  <= 1'b1;
                     cnt   <= sh_delay - CNTR_WIDTH'(1);
                  end
               end
               DELAY, LOW: begin
                  cnt <= cnt - CNTR_WIDTH'(1);
               end
               HIGH: begin
                  if (cnt != '0) begin
                     cnt <= cnt - CNTR_WIDTH'(1);
                  end else if (pulse_cnt == sh_count) begin
                     trig_out <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     if (sh_rearm) begin
                        state     <= ARMED;
                        armed     <= 1'b1;
                        pulse_cnt <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     state    <= LOW;
                     trig_out <= 1'b0;
                     cnt      <= sh_low_m1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gpio_trigger_sequencer.sv
// Self-checking bench for gpio_trigger_sequencer: table-driven bursts plus
// hand-written abort, re-arm and reset sequences, checked via a scoreboard.
module tb_gpio_trigger_sequencer;

   localparam int CW = 32;
   localparam int PW = 16;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          arm, disarm, soft_trig, ext_trig;
   logic [CW-1:0] cfg_delay, cfg_period;
   logic [PW-1:0] cfg_width, cfg_count;
   logic          cfg_rearm;
   logic          trig_out, armed, busy, done;
   logic [PW-1:0] pulse_cnt;

   typedef struct {
      int delay;
      int width;
      int period;
      int count;
      bit rearm;
      bit use_ext;
      int exp_done_at;
      int exp_pulses;
   } vec_t;

   typedef struct {
      int off;
      bit trig;
      bit armed;
      bit busy;
      bit done;
      int pcnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   gpio_trigger_sequencer dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .arm        (arm),
      .disarm     (disarm),
      .soft_trig  (soft_trig),
      .ext_trig   (ext_trig),
      .cfg_delay  (cfg_delay),
      .cfg_width  (cfg_width),
      .cfg_period (cfg_period),
      .cfg_count  (cfg_count),
      .cfg_rearm  (cfg_rearm),
      .trig_out   (trig_out),
      .armed      (armed),
      .busy       (busy),
      .done       (done),
      .pulse_cnt  (pulse_cnt)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic apply_cfg(input vec_t v);
      cfg_delay  = CW'(v.delay);
      cfg_width  = PW'(v.width);
      cfg_period = CW'(v.period);
      cfg_count  = PW'(v.count);
      cfg_rearm  = v.rearm;
   endtask

   // Closed-form expectation for the state after edge T+o, where T is the
   // edge that first samples the trigger event.
   function automatic exp_t expect_at(input vec_t v, input int o);
      exp_t e;
      int w, c, l, p, endo, pc;
      w    = (v.width == 0) ? 1 : v.width;
      c    = (v.count == 0) ? 1 : v.count;
      l    = (v.period > w) ? v.period - w : 1;
      p    = w + l;
      endo = 1 + v.delay + (c - 1) * p + w;
      e.off  = o;
      e.trig = 1'b0;
      for (int k = 0; k < c; k++)
         if (o >= 1 + v.delay + k * p && o < 1 + v.delay + k * p + w) e.trig = 1'b1;
      e.done  = (o == endo);
      e.busy  = (o >= 1) && (o < endo);
      e.armed = (o == 0) || (v.rearm && o >= endo);
      if (o < 1 + v.delay) pc = 0;
      else pc = (o - 1 - v.delay) / p + 1;
      if (pc > c) pc = c;
      if (v.rearm && o >= endo) pc = 0;
      e.pcnt = pc;
      return e;
   endfunction

   function automatic vec_t random_cfg();
      vec_t r;
      r.delay       = int'($urandom_range(0, 9));
      r.width       = int'($urandom_range(1, 7));
      r.period      = int'($urandom_range(0, 12));
      r.count       = int'($urandom_range(1, 5));
      r.rearm       = 1'b1;
      r.use_ext     = 1'b0;
      r.exp_done_at = 0;
      r.exp_pulses  = 0;
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the arm edge.
   task automatic do_arm(input vec_t v);
      apply_cfg(v);
      arm = 1'b1;
      @(posedge aclk);
      #1 arm = 1'b0;
      @(negedge aclk);
      check("arm armed", armed, 1);
      check("arm pulse_cnt", pulse_cnt, 0);
   endtask

   // Pushes the expected trace, then drives the trigger; returns at the
   // negedge after the edge that samples the event (offset 0).
   task automatic fire(input vec_t v, input int npush);
      for (int o = 0; o < npush; o++) exp_q.push_back(expect_at(v, o));
      if (v.use_ext) begin
         @(posedge aclk);
         #3 ext_trig = 1'b1;
         repeat (3) @(posedge aclk);
      end else begin
         soft_trig = 1'b1;
         @(posedge aclk);
         #1 soft_trig = 1'b0;
      end
      @(negedge aclk);
   endtask

   task automatic drain(input vec_t v, input vec_t alt, input int n, input bit scramble,
                        output int done_at, output int max_pcnt);
      exp_t e;
      done_at  = -1;
      max_pcnt = 0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge aclk);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: queue empty at cycle %0d", i);
            break;
         end
         e = exp_q.pop_front();
         check($sformatf("o%0d trig_out", e.off), trig_out, e.trig);
         check($sformatf("o%0d armed", e.off), armed, e.armed);
         check($sformatf("o%0d busy", e.off), busy, e.busy);
         check($sformatf("o%0d done", e.off), done, e.done);
         check($sformatf("o%0d pulse_cnt", e.off), pulse_cnt, e.pcnt);
         if (done === 1'b1 && done_at < 0) done_at = e.off;
         if (int'(pulse_cnt) > max_pcnt) max_pcnt = int'(pulse_cnt);
         // Mid-burst pokes: config changes, a stray arm and a stray soft trigger.
         if (scramble && e.off == 2) apply_cfg(alt);
         if (e.off == 3 && 4 < v.exp_done_at) begin
            arm       = 1'b1;
            soft_trig = 1'b1;
         end
         if (e.off == 4) begin
            arm       = 1'b0;
            soft_trig = 1'b0;
         end
      end
   endtask

   vec_t vecs[6];
   vec_t v_abort, v_re1, v_re2, v_rst, v_ext, alt;
   int   da, mp;

   initial begin
      vecs[0] = '{5, 3, 10, 4, 1'b0, 1'b0, 39, 4};
      vecs[1] = '{0, 0, 0,  0, 1'b0, 1'b1, 2,  1};
      vecs[2] = '{0, 4, 2,  3, 1'b0, 1'b0, 15, 3};
      vecs[3] = '{2, 1, 3,  2, 1'b0, 1'b0, 7,  2};
      vecs[4] = '{1, 2, 2,  2, 1'b0, 1'b1, 7,  2};
      vecs[5] = '{3, 2, 5,  0, 1'b0, 1'b0, 6,  1};
      v_abort = '{0, 3, 6,  4, 1'b0, 1'b0, 22, 2};
      v_re1   = '{1, 2, 4,  2, 1'b1, 1'b0, 8,  2};
      v_re2   = '{0, 1, 0,  1, 1'b0, 1'b0, 2,  1};
      v_rst   = '{20, 2, 4, 1, 1'b0, 1'b0, 23, 1};
      v_ext   = '{1, 1, 0,  1, 1'b0, 1'b1, 3,  1};

      aresetn = 1'b1;
      arm = 1'b0; disarm = 1'b0; soft_trig = 1'b0; ext_trig = 1'b0;
      apply_cfg(v_re2);
      #1 aresetn = 1'b0;
      #2;
      check("reset trig_out", trig_out, 0);
      check("reset armed", armed, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset pulse_cnt", pulse_cnt, 0);
      repeat (3) @(posedge aclk);
      @(negedge aclk) aresetn = 1'b1;
      @(negedge aclk);
      check("idle armed", armed, 0);
      check("idle busy", busy, 0);

      // Table-driven bursts with config scrambled mid-burst.
      foreach (vecs[i]) begin
         do_arm(vecs[i]);
         fire(vecs[i], vecs[i].exp_done_at + 3);
         alt = random_cfg();
         drain(vecs[i], alt, vecs[i].exp_done_at + 3, 1'b1, da, mp);
         check($sformatf("vec%0d done_at", i), da, vecs[i].exp_done_at);
         check($sformatf("vec%0d pulses", i), mp, vecs[i].exp_pulses);
         ext_trig = 1'b0;
         repeat (4) @(negedge aclk);
      end

      // Abort during the second pulse, then arm and disarm together.
      do_arm(v_abort);
      fire(v_abort, 9);
      drain(v_abort, v_abort, 9, 1'b0, da, mp);
      disarm = 1'b1;
      @(posedge aclk);
      #1 disarm = 1'b0;
      @(negedge aclk);
      check("abort trig_out", trig_out, 0);
      check("abort busy", busy, 0);
      check("abort armed", armed, 0);
      check("abort done", done, 0);
      check("abort pulse_cnt", pulse_cnt, 2);
      for (int i = 0; i < 15; i++) begin
         @(negedge aclk);
         check($sformatf("post-abort c%0d done", i), done, 0);
         check($sformatf("post-abort c%0d trig_out", i), trig_out, 0);
      end
      arm = 1'b1;
      disarm = 1'b1;
      @(posedge aclk);
      #1 begin arm = 1'b0; disarm = 1'b0; end
      @(negedge aclk);
      check("arm+disarm armed", armed, 0);
      check("arm+disarm pulse_cnt", pulse_cnt, 2);
      soft_trig = 1'b1;
      repeat (3) @(posedge aclk);
      #1 soft_trig = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         check($sformatf("idle trig c%0d trig_out", i), trig_out, 0);
         check($sformatf("idle trig c%0d busy", i), busy, 0);
      end

      // Re-arm: the new config is taken at completion, next event starts burst two.
      do_arm(v_re1);
      fire(v_re1, v_re1.exp_done_at + 1);
      drain(v_re1, v_re2, v_re1.exp_done_at + 1, 1'b1, da, mp);
      check("rearm1 done_at", da, v_re1.exp_done_at);
      check("rearm1 pulses", mp, v_re1.exp_pulses);
      fire(v_re2, v_re2.exp_done_at + 3);
      alt = random_cfg();
      drain(v_re2, alt, v_re2.exp_done_at + 3, 1'b1, da, mp);
      check("rearm2 done_at", da, v_re2.exp_done_at);
      check("rearm2 pulses", mp, v_re2.exp_pulses);

      // Asynchronous reset in the middle of a delay.
      do_arm(v_rst);
      fire(v_rst, 6);
      drain(v_rst, v_rst, 6, 1'b0, da, mp);
      #2 aresetn = 1'b0;
      #1;
      check("async reset trig_out", trig_out, 0);
      check("async reset armed", armed, 0);
      check("async reset busy", busy, 0);
      check("async reset done", done, 0);
      check("async reset pulse_cnt", pulse_cnt, 0);
      ext_trig = 1'b1;
      repeat (2) @(posedge aclk);
      @(negedge aclk) aresetn = 1'b1;
      repeat (4) @(negedge aclk);
      check("post-reset armed", armed, 0);
      check("post-reset busy", busy, 0);
      do_arm(v_ext);
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk);
         check($sformatf("ext held c%0d trig_out", i), trig_out, 0);
         check($sformatf("ext held c%0d busy", i), busy, 0);
         check($sformatf("ext held c%0d armed", i), armed, 1);
      end
      ext_trig = 1'b0;
      repeat (4) @(negedge aclk);
      fire(v_ext, v_ext.exp_done_at + 3);
      alt = random_cfg();
      drain(v_ext, alt, v_ext.exp_done_at + 3, 1'b1, da, mp);
      check("ext re-edge done_at", da, v_ext.exp_done_at);
      check("ext re-edge pulses", mp, v_ext.exp_pulses);
      ext_trig = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gpio_trigger_sequencer.md
# gpio_trigger_sequencer

Programmable trigger sequencer for the GPIO trigger path. It arms on command from the PS configuration registers and waits for a trigger event: either a soft trigger, or a rising edge on the synchronized external GPIO trigger input. After a programmable delay it emits a burst of trigger pulses with programmable width, period and count. Its `trig_out` drives the trigger output pin stage and the acquisition start logic in place of a sticky trigger latch.

## Interface
Parameters:
- `CNTR_WIDTH`, 32: width of the delay and period counters and their config ports.
- `PULSE_WIDTH`, 16: width of `cfg_width`, `cfg_count` and `pulse_cnt`.

Ports:
- `aclk`, input, 1: the single clock; all logic is on its rising edge.
- `aresetn`, input, 1: reset, asynchronous and active-low.
- `arm`, input, 1: 1-cycle strobe; arms the sequencer from IDLE.
- `disarm`, input, 1: synchronous abort from any state.
- `soft_trig`, input, 1: level; any cycle high in ARMED is a trigger event.
- `ext_trig`, input, 1: raw asynchronous GPIO trigger input.
- `cfg_delay`, input, CNTR_WIDTH: cycles from trigger event to first pulse.
- `cfg_width`, input, PULSE_WIDTH: pulse high time in cycles; 0 is treated as 1.
- `cfg_period`, input, CNTR_WIDTH: cycles from one pulse start to the next pulse start.
- `cfg_count`, input, PULSE_WIDTH: pulses per burst; 0 is treated as 1.
- `cfg_rearm`, input, 1: after a burst, return to ARMED (1) or to IDLE (0).
- `trig_out`, output, 1: registered trigger pulse output.
- `armed`, output, 1: high while in ARMED.
- `busy`, output, 1: high in DELAY, HIGH and LOW.
- `done`, output, 1: 1-cycle pulse when a burst completes.
- `pulse_cnt`, output, PULSE_WIDTH: number of pulses emitted in the current or last burst.

## Operation
- States: IDLE, ARMED, DELAY, HIGH, LOW.
- All `cfg_*` inputs are latched into shadow registers on the accepted `arm`, and again on each re-arm. Changing them mid-burst has no effect.
- IDLE:
  - `arm` = 1 → ARMED, and `pulse_cnt` clears to 0.
  - `arm` is ignored in every other state.
- ARMED:
  - A trigger event is `soft_trig` OR `ext_rise`.
  - On an event with delay = 0 → HIGH.
  - On an event with delay > 0 → DELAY, with the counter loaded to delay−1.
  - Events are not queued. An event outside ARMED is dropped.
- DELAY: the counter decrements each cycle; at 0 → HIGH.
- HIGH:
  - `trig_out` = 1 for W = max(`cfg_width`, 1) cycles.
  - `pulse_cnt` increments on the entry cycle.
  - At the end of the high time:
    - if `pulse_cnt` = C (C = max(`cfg_count`, 1)), the burst completes;
    - otherwise → LOW.
- LOW: `trig_out` = 0 for L = max(`cfg_period` − W, 1) cycles, then → HIGH. The effective period is W + L.
- Burst completion:
  - `done` = 1 for one cycle.
  - Next state is ARMED if latched `cfg_rearm` = 1 (config re-latched, `pulse_cnt` cleared); otherwise IDLE.
- `disarm` has priority over everything:
  - next state is IDLE;
  - `trig_out`, `busy` and `armed` drop on the next edge;
  - `done` is not pulsed;
  - `pulse_cnt` holds its value.
- `disarm` and `arm` in the same cycle: `disarm` wins.
- Counters never wrap. Comparisons are against latched values, so cfg_delay = 2^CNTR_WIDTH−1 simply runs the full count.

## Timing
- Reset (async assert, sync deassert externally): state IDLE; `trig_out`, `armed`, `busy`, `done` = 0; `pulse_cnt` = 0; synchronizer flops = 0.
- All outputs are registered.
- `armed` rises one cycle after the `arm` strobe.
- `ext_trig` uses a 2-FF synchronizer plus an edge flop. `ext_rise` is high for one cycle, two edges after the first edge that samples `ext_trig` high.
- Event sampled at edge T: `trig_out` rises at edge T+1+`cfg_delay`.
- `done` is asserted on the same edge that `trig_out` falls after the last pulse.
- Re-arm: `armed` is high on that same edge. An event on the following edge is accepted.

## Structure
- Package `gpio_trig_pkg` holds:
  - the state enum (IDLE, ARMED, DELAY, HIGH, LOW);
  - default widths;
  - the `max(x,1)` clamp function.
- Sub-module `trig_sync_edge`: 2-FF synchronizer plus rising-edge detector, asynchronous active-low reset, 1-bit output `ext_rise`.
- Top level contains: the FSM, one CNTR_WIDTH down-counter shared by DELAY, HIGH and LOW, the `pulse_cnt` register and the config shadow registers.

## Test plan
- Delay: arm, with delay = 5, width = 3, period = 10, count = 4, rearm = 0; soft_trig at edge T → pulses rise at T+6, T+16, T+26, T+36, each 3 cycles high; `done` at T+39; `pulse_cnt` = 4; then IDLE.
- Zero config: delay = 0, width = 0, count = 0; ext_trig raised (async, mid-cycle) → exactly one 1-cycle pulse, 3 edges after the first edge sampling ext_trig high.
- Period clamp: period = 2, width = 4, count = 3 → high 4 / low 1 / high 4 / low 1 / high 4.
- Abort: `disarm` during the 2nd pulse → `trig_out` low next edge, IDLE, no `done`, `pulse_cnt` = 2. `arm` and `disarm` in the same cycle → stays IDLE.
- Re-arm: rearm = 1, count = 2 → `armed` high on the `done` edge. A soft_trig during the burst is ignored; a soft_trig after `done` starts a new burst with newly latched config.
- Reset: `aresetn` low mid-DELAY → all outputs 0 immediately, without waiting for a clock edge; after release, IDLE; ext_trig held high → no event until armed and a new rising edge arrives.
